ks_addsub_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone adder/subtractor; successor to the fixed 32-bit combinational adder.

---
 rtl/ks_addsub_pipe.sv | 196 +++++++++++++++++++
 tb/tb_ks_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with optional signed saturation and C/V/Z/N flags.
// Valid/ready on both sides; a single global stall freezes every stage in place.
module ks_addsub_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [TAG_W-1:0] out_tag
);
  localparam int unsigned LEVELS = $clog2(WIDTH);
  // Side info travelling with each op: {tag, sat, a_msb, g_msb, p}
  localparam int unsigned SIDE_W = TAG_W + 3 + WIDTH;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_c, r_out_v, r_out_z, r_out_n;
  logic [TAG_W-1:0] r_out_tag;

  logic w_stall, w_en;
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  // Stage 0: operand conditioning and bitwise generate/propagate
  logic             w_sub, w_c0;
  logic [WIDTH-1:0] w_bp, w_p0, w_g0;
  assign w_sub = in_op[0];
  assign w_c0  = in_op[1] ? (in_cin ^ w_sub) : w_sub;
  assign w_bp  = in_b ^ {WIDTH{w_sub}};
  assign w_p0  = in_a ^ w_bp;
  assign w_g0  = in_a & w_bp;

  // Entry 0 of the prefix vector is c0 (G=c0, P=0); entry i is bit i-1, so that
  // after the prefix tree entry i holds the carry into bit i.
  logic              r_s0_valid;
  logic [WIDTH-1:0]  r_s0_g, r_s0_p;
  logic [SIDE_W-1:0] r_s0_side;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_g     <= '0;
      r_s0_p     <= '0;
      r_s0_side  <= '0;
    end else if (w_en) begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_g    <= {w_g0[WIDTH-2:0], w_c0};
        r_s0_p    <= {w_p0[WIDTH-2:0], 1'b0};
        r_s0_side <= {in_tag, in_sat, in_a[WIDTH-1], w_g0[WIDTH-1], w_p0};
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int Span   = 1 << k;
    localparam bit RegHere = ((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1);

    logic [WIDTH-1:0]  w_g_in, w_p_in, w_g_nx, w_g_out;
    logic [SIDE_W-1:0] w_side_in, w_side_out;
    logic              w_valid_in, w_valid_out;

    if (k == 0) begin : g_src
      assign w_g_in     = r_s0_g;
      assign w_p_in     = r_s0_p;
      assign w_side_in  = r_s0_side;
      assign w_valid_in = r_s0_valid;
    end else begin : g_src
      assign w_g_in     = g_lvl[k-1].w_g_out;
      assign w_p_in     = g_lvl[k-1].g_pn.w_p_out;
      assign w_side_in  = g_lvl[k-1].w_side_out;
      assign w_valid_in = g_lvl[k-1].w_valid_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_gbit
      if (i >= Span) begin : g_op
        assign w_g_nx[i] = w_g_in[i] | (w_p_in[i] & w_g_in[i-Span]);
      end else begin : g_pass
        assign w_g_nx[i] = w_g_in[i];
      end
    end

    // Group propagate is only consumed by the following level.
    if (k + 1 < LEVELS) begin : g_pn
      logic [WIDTH-1:0] w_p_nx, w_p_out;
      for (genvar i = 0; i < WIDTH; i++) begin : g_pbit
        if (i >= Span) begin : g_op
          assign w_p_nx[i] = w_p_in[i] & w_p_in[i-Span];
        end else begin : g_pass
          assign w_p_nx[i] = w_p_in[i];
        end
      end
      if (RegHere) begin : g_reg
        logic [WIDTH-1:0] r_p;
        always_ff @(posedge clk) begin
          if (rst)       r_p <= '0;
          else if (w_en) r_p <= w_p_nx;
        end
        assign w_p_out = r_p;
      end else begin : g_comb
        assign w_p_out = w_p_nx;
      end
    end

    if (RegHere) begin : g_reg
      logic [WIDTH-1:0]  r_g;
      logic [SIDE_W-1:0] r_side;
      logic              r_valid;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_g     <= '0;
          r_side  <= '0;
          r_valid <= 1'b0;
        end else if (w_en) begin
          r_g     <= w_g_nx;
          r_side  <= w_side_in;
          r_valid <= w_valid_in;
        end
      end
      assign w_g_out     = r_g;
      assign w_side_out  = r_side;
      assign w_valid_out = r_valid;
    end else begin : g_comb
      assign w_g_out     = w_g_nx;
      assign w_side_out  = w_side_in;
      assign w_valid_out = w_valid_in;
    end
  end

  // Final stage: sum, flags, saturation
  logic [WIDTH-1:0] w_carry, w_pf, w_sum_raw, w_sum;
  logic [TAG_W-1:0] w_tag;
  logic             w_sat, w_a_msb, w_g_msb, w_c, w_v, w_valid_f;

  assign w_carry   = g_lvl[LEVELS-1].w_g_out;
  assign w_valid_f = g_lvl[LEVELS-1].w_valid_out;
  assign {w_tag, w_sat, w_a_msb, w_g_msb, w_pf} = g_lvl[LEVELS-1].w_side_out;

  assign w_sum_raw = w_pf ^ w_carry;
  assign w_c       = w_g_msb | (w_pf[WIDTH-1] & w_carry[WIDTH-1]);
  // Operand signs agree when the MSB propagate bit is 0.
  assign w_v       = ~w_pf[WIDTH-1] & (w_sum_raw[WIDTH-1] ^ w_a_msb);

  always_comb begin
    w_sum = w_sum_raw;
    if (w_sat && w_v) begin
      w_sum = w_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_c     <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_z     <= 1'b0;
      r_out_n     <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_en) begin
      r_out_valid <= w_valid_f;
      r_out_sum   <= w_sum;
      r_out_c     <= w_c;
      r_out_v     <= w_v;
      r_out_z     <= (w_sum == '0);
      r_out_n     <= w_sum[WIDTH-1];
      r_out_tag   <= w_tag;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_c     = r_out_c;
  assign out_v     = r_out_v;
  assign out_z     = r_out_z;
  assign out_n     = r_out_n;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Randomized bench for ks_addsub_pipe: scoreboard against an arithmetic model,
// directed corner cases, latency, stall-hold and mid-flight reset checks.
module tb_ks_addsub_pipe;
  localparam int W      = 32;
  localparam int RE     = 2;
  localparam int TW     = 4;
  localparam int LEVELS = $clog2(W);
  localparam int LAT    = 2 + (LEVELS + RE - 1) / RE;

  localparam longint MaxS = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint MinS = -(64'sd1 <<< (W - 1));
  localparam longint TwoW = 64'sd1 <<< W;

  typedef struct {
    logic [W-1:0]  sum;
    logic [3:0]    flags;  // {c, v, z, n}
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat_chk;
  } exp_t;

  logic          clk, rst;
  logic          in_valid, in_ready, in_cin, in_sat;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_c, out_v, out_z, out_n;
  logic [W-1:0]  out_sum;
  logic [TW-1:0] out_tag;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   rdy_rand = 0;
  bit   dir_en = 0;
  exp_t dir_exp;
  exp_t q[$];

  ks_addsub_pipe #(.WIDTH(W), .REG_EVERY(RE), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_cin(in_cin), .in_sat(in_sat), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n), .out_tag(out_tag)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Exact integer arithmetic; the result is reduced mod 2^W afterwards.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin, input logic sat);
    exp_t   e;
    longint sa, sb, ua, ub, ex, es, eu;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({{(64-W){1'b0}}, a});
    ub = longint'({{(64-W){1'b0}}, b});
    ex = (op[1] && cin) ? 64'sd1 : 64'sd0;
    if (!op[0]) begin
      es = sa + sb + ex;
      eu = ua + ub + ex;
      c  = (eu >= TwoW);
    end else begin
      es = sa - sb - ex;
      eu = ua - ub - ex;
      c  = (eu >= 0);
    end
    v = (es > MaxS) || (es < MinS);
    e.sum = eu[W-1:0];
    if (sat && v) e.sum = (es > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    e.flags   = {c, v, (e.sum == '0), e.sum[W-1]};
    e.tag     = '0;
    e.cyc     = 0;
    e.lat_chk = 0;
    return e;
  endfunction

  initial begin : monitor
    exp_t          e;
    logic          prev_stall;
    logic [W-1:0]  h_sum;
    logic [3:0]    h_flags;
    logic [TW-1:0] h_tag;
    prev_stall = 0;
    h_sum = '0;
    h_flags = '0;
    h_tag = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_sum", out_sum, h_sum);
        check_eq("hold_flags", {out_c, out_v, out_z, out_n}, h_flags);
        check_eq("hold_tag", out_tag, h_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          check_eq("sum", out_sum, e.sum);
          check_eq("flags_cvzn", {out_c, out_v, out_z, out_n}, e.flags);
          check_eq("tag", out_tag, e.tag);
          if (e.lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'(LAT));
        end
      end
      prev_stall = !rst && out_valid && !out_ready;
      h_sum   = out_sum;
      h_flags = {out_c, out_v, out_z, out_n};
      h_tag   = out_tag;
      if (rst) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        e = dir_en ? dir_exp : model(in_a, in_b, in_op, in_cin, in_sat);
        e.tag     = in_tag;
        e.cyc     = cyc;
        e.lat_chk = !rdy_rand;
        q.push_back(e);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic cin, input logic sat, input logic [TW-1:0] tag);
    int n;
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_cin = cin; in_sat = sat; in_tag = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic send_d(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic cin, input logic sat, input logic [TW-1:0] tag,
                        input logic [W-1:0] sum, input logic [3:0] flags);
    dir_exp.sum   = sum;
    dir_exp.flags = flags;
    send(a, b, op, cin, sat, tag);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return 1;
      default: return $urandom;
    endcase
  endfunction

  task automatic send_rand(input int i);
    logic [TW-1:0] t;
    t = i[TW-1:0];
    send(pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), t);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) check_eq("drain_timeout", q.size(), 0);
    cycles(2);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; in_cin = 0; in_sat = 0;
    in_tag = '0;
    cycles(3);
    rst = 0;
    @(negedge clk);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_sum", out_sum, 0);
    check_eq("reset_flags", {out_c, out_v, out_z, out_n}, 0);
    check_eq("reset_tag", out_tag, 0);
    cycles(1);

    // Directed corners, expected values written out by hand
    dir_en = 1;
    send_d(32'h7FFF_FFFF, 32'h1, 2'b00, 0, 0, 4'h1, 32'h8000_0000, 4'b0101);
    send_d(32'h7FFF_FFFF, 32'h1, 2'b00, 0, 1, 4'h2, 32'h7FFF_FFFF, 4'b0100);
    send_d(32'h0,         32'h1, 2'b01, 0, 0, 4'h3, 32'hFFFF_FFFF, 4'b0001);
    send_d(32'h5,         32'h5, 2'b01, 1, 0, 4'h4, 32'h0,         4'b1010);
    send_d(32'hFFFF_FFFF, 32'h0, 2'b10, 1, 0, 4'h5, 32'h0,         4'b1010);
    send_d(32'd10,        32'd3, 2'b11, 1, 0, 4'h6, 32'd6,         4'b1000);
    send_d(32'h8000_0000, 32'h1, 2'b01, 0, 1, 4'h7, 32'h8000_0000, 4'b1101);
    drain();
    dir_en = 0;

    // Back-to-back stream with the sink always ready: latency checked per op
    for (int i = 0; i < 100; i++) send_rand(i);
    drain();

    // Random back-pressure and input gaps
    rdy_rand = 1;
    cycles(2);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      send_rand(i);
    end
    drain();
    rdy_rand = 0;
    cycles(2);

    // Reset with LAT-1 ops in flight: nothing may emerge afterwards
    for (int i = 0; i < LAT - 1; i++) send_rand(i);
    rst = 1;
    cycles(1);
    rst = 0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_sum", out_sum, 0);
    check_eq("midrst_flags", {out_c, out_v, out_z, out_n}, 0);
    check_eq("midrst_tag", out_tag, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    cycles(LAT + 3);
    dir_en = 1;
    send_d(32'h1234_5678, 32'h1111_1111, 2'b00, 0, 0, 4'h9, 32'h2345_6789, 4'b0000);
    drain();
    dir_en = 0;
    for (int i = 0; i < 20; i++) send_rand(i);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
